// File: rtl/spi_xfer_sequencer_if.sv
// spi_xfer_sequencer_if
//   Signal bundle between the APB register block / baud generator side
//   (master modport) and the transfer sequencer (slave modport).
//
//   Handshake semantics: there is no valid/ready back-pressure on this
//   boundary. send_data_i is a one-PCLK request pulse and is never stalled:
//   the sequencer either starts, queues one request, or reports overrun_o.
//   load_o, receive_data_o, overrun_o and abort_o are one-PCLK event pulses
//   that the consumer must take in the cycle they are high.
//
//   Ports (from the sequencer's point of view):
//     spe_i, mstr_i, spiswai_i, spi_mode_i  enable qualifiers
//     send_data_i                           data register written (pulse)
//     miso_receive_sclk_i/_sclk0_i          sample strobes from baud generator
//     ss_o, tip_o                           slave select (active-low), busy
//     load_o, receive_data_o, overrun_o,
//     abort_o                               event pulses
//     bit_cnt_o                             bits sampled in current transfer
//     state_dbg, pend_dbg                   FSM state and queued-request flag
interface spi_xfer_sequencer_if #(
  parameter int DATA_WIDTH = 8
);
  localparam int BCW = $clog2(DATA_WIDTH + 1);

  logic           spe_i;
  logic           mstr_i;
  logic           spiswai_i;
  logic [1:0]     spi_mode_i;
  logic           send_data_i;
  logic           miso_receive_sclk_i;
  logic           miso_receive_sclk0_i;
  logic           ss_o;
  logic           tip_o;
  logic           load_o;
  logic           receive_data_o;
  logic           overrun_o;
  logic           abort_o;
  logic [BCW-1:0] bit_cnt_o;
  logic [1:0]     state_dbg;
  logic           pend_dbg;

  modport master (
    output spe_i, mstr_i, spiswai_i, spi_mode_i, send_data_i,
           miso_receive_sclk_i, miso_receive_sclk0_i,
    input  ss_o, tip_o, load_o, receive_data_o, overrun_o, abort_o,
           bit_cnt_o, state_dbg, pend_dbg
  );

  modport slave (
    input  spe_i, mstr_i, spiswai_i, spi_mode_i, send_data_i,
           miso_receive_sclk_i, miso_receive_sclk0_i,
    output ss_o, tip_o, load_o, receive_data_o, overrun_o, abort_o,
           bit_cnt_o, state_dbg, pend_dbg
  );
endinterface

// File: rtl/spi_xfer_sequencer.sv
// spi_xfer_sequencer
//   Master-mode SPI transfer sequencer. Owns slave select, requests the
//   shift-register load, counts sampled bits from the baud generator
//   strobes and reports byte completion, overrun and abort.
//
//   Ports:
//     PCLK      system clock
//     PRESET_n  asynchronous active-low reset
//     bus       spi_xfer_sequencer_if.slave (see interface header)
//
//   Parameters:
//     DATA_WIDTH  bits per transfer (2..16)
//     SS_SETUP    PCLK cycles from load to ss_o falling (>=1)
//     SS_HOLD     PCLK cycles ss_o stays high after a transfer (>=1)
module spi_xfer_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int SS_SETUP   = 2,
  parameter int SS_HOLD    = 2
) (
  input logic                 PCLK,
  input logic                 PRESET_n,
  spi_xfer_sequencer_if.slave bus
);
  localparam int BCW  = $clog2(DATA_WIDTH + 1);
  localparam int DMAX = (SS_SETUP > SS_HOLD) ? SS_SETUP : SS_HOLD;
  localparam int DCW  = $clog2(DMAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t         state;
  logic [DCW-1:0] dly_cnt;
  logic [BCW-1:0] bit_cnt;
  logic           pend;
  logic           ss;
  logic           tip;
  logic           load;
  logic           rx_done;
  logic           ovr;
  logic           abrt;

  logic en;
  logic smp;
  logic req;

  // Wait mode only keeps the sequencer running when stop-in-wait is clear;
  // stop mode (1x) always disables it.
  assign en  = bus.spe_i & bus.mstr_i &
               ((bus.spi_mode_i == 2'b00) |
                ((bus.spi_mode_i == 2'b01) & ~bus.spiswai_i));
  assign smp = bus.miso_receive_sclk_i | bus.miso_receive_sclk0_i;
  assign req = bus.send_data_i | pend;

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      state   <= IDLE;
      dly_cnt <= '0;
      bit_cnt <= '0;
      pend    <= 1'b0;
      ss      <= 1'b1;
      tip     <= 1'b0;
      load    <= 1'b0;
      rx_done <= 1'b0;
      ovr     <= 1'b0;
      abrt    <= 1'b0;
    end else begin
      load    <= 1'b0;
      rx_done <= 1'b0;
      abrt    <= 1'b0;
      // The queue is one deep: a request while one is already queued is lost.
      ovr     <= bus.send_data_i & pend;
      // Default: a request queues; start and abort below override this.
      if (bus.send_data_i) pend <= 1'b1;

      case (state)
        IDLE: begin
          if (en && req) begin
            state   <= SETUP;
            tip     <= 1'b1;
            load    <= 1'b1;
            bit_cnt <= '0;
            dly_cnt <= '0;
            pend    <= 1'b0;
          end
        end
        SETUP: begin
          if (!en) begin
            state   <= IDLE;
            tip     <= 1'b0;
            abrt    <= 1'b1;
            pend    <= 1'b0;
            dly_cnt <= '0;
          end else if (dly_cnt == DCW'(SS_SETUP - 1)) begin
            state   <= XFER;
            ss      <= 1'b0;
            dly_cnt <= '0;
          end else begin
            dly_cnt <= dly_cnt + DCW'(1);
          end
        end
        XFER: begin
          // Loss of enable beats a coincident final strobe.
          if (!en) begin
            state   <= IDLE;
            ss      <= 1'b1;
            tip     <= 1'b0;
            abrt    <= 1'b1;
            bit_cnt <= '0;
            pend    <= 1'b0;
          end else if (smp) begin
            if (bit_cnt == BCW'(DATA_WIDTH - 1)) begin
              state   <= HOLD;
              ss      <= 1'b1;
              tip     <= 1'b0;
              rx_done <= 1'b1;
              bit_cnt <= BCW'(DATA_WIDTH);
            end else begin
              bit_cnt <= bit_cnt + BCW'(1);
            end
          end
        end
        HOLD: begin
          // Always passes through IDLE, so a queued request loads one
          // cycle after the hold time expires.
          if (dly_cnt == DCW'(SS_HOLD - 1)) begin
            state   <= IDLE;
            bit_cnt <= '0;
            dly_cnt <= '0;
          end else begin
            dly_cnt <= dly_cnt + DCW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ss_o           = ss;
  assign bus.tip_o          = tip;
  assign bus.load_o         = load;
  assign bus.receive_data_o = rx_done;
  assign bus.overrun_o      = ovr;
  assign bus.abort_o        = abrt;
  assign bus.bit_cnt_o      = bit_cnt;
  assign bus.state_dbg      = state;
  assign bus.pend_dbg       = pend;
endmodule

// File: doc/spi_xfer_sequencer.md
# spi_xfer_sequencer

Master-mode transfer sequencer for the SPI controller. It sits between the APB register block and the SPI baud generator/shifter. It owns the slave-select line that gates the baud generator, and it tells the shift register when to load. It counts sampled bits using the generator's strobes, then signals byte completion, overrun and abort back to the status logic.

## Interface
- DATA_WIDTH, 8, bits per transfer (2..16)
- SS_SETUP, 2, PCLK cycles between load and ss_o falling (≥1)
- SS_HOLD, 2, PCLK cycles ss_o stays high after a transfer before the next may start (≥1)

- PCLK  in  1  system clock
- PRESET_n  in  1  reset, asynchronous, active-low
- spe_i  in  1  SPI system enable
- mstr_i  in  1  master mode select
- spiswai_i  in  1  stop-in-wait control
- spi_mode_i  in  2  00 run, 01 wait, 1x stop
- send_data_i  in  1  one-PCLK pulse: data register written
- miso_receive_sclk_i, miso_receive_sclk0_i  in  1 each  sample strobes from baud generator
- ss_o  out  1  slave select to pad and baud generator ss input, active-low
- tip_o  out  1  transfer in progress
- load_o  out  1  one-cycle pulse: copy data register into shift register
- receive_data_o  out  1  one-cycle pulse: DATA_WIDTH bits received
- overrun_o  out  1  one-cycle pulse: send request dropped
- abort_o  out  1  one-cycle pulse: transfer aborted
- bit_cnt_o  out  $clog2(DATA_WIDTH+1)  bits sampled in current transfer

## Operation
- Enable condition: en = spe_i & mstr_i & (spi_mode_i==00 | (spi_mode_i==01 & !spiswai_i)).
- Sample strobe: smp = miso_receive_sclk_i | miso_receive_sclk0_i.
- pend flag, one deep:
  - Set by send_data_i when a start is not taken that cycle.
  - A send_data_i arriving while pend=1 pulses overrun_o and is dropped; pend stays 1.
  - pend is cleared on start and on abort.
- FSM states: IDLE, SETUP, XFER, HOLD.
  - IDLE: ss_o=1, tip_o=0.
    - If en & (send_data_i | pend): go to SETUP, pulse load_o, clear bit_cnt, clear pend.
    - If en=0, requests set or keep pend.
  - SETUP: ss_o=1, tip_o=1.
    - Counts SS_SETUP cycles, then goes to XFER.
    - If en falls: go to IDLE and pulse abort_o.
  - XFER: ss_o=0, tip_o=1.
    - Each smp increments bit_cnt.
    - smp while bit_cnt==DATA_WIDTH-1: set bit_cnt=DATA_WIDTH, pulse receive_data_o, go to HOLD.
    - en falling: go to IDLE, pulse abort_o, clear bit_cnt and pend. A coincident final smp is ignored: abort wins.
  - HOLD: ss_o=1, tip_o=0.
    - Counts SS_HOLD cycles, then goes to IDLE; bit_cnt is cleared on that exit.
    - A request pending at that point starts from IDLE on the next cycle.
- Simultaneous events:
  - send_data_i in the same cycle as the final smp sets pend.
  - send_data_i in IDLE with en=1 starts directly; pend is not set.
- Reset mid-operation: all state returns to the reset values immediately; no pulse is issued.
- Reset values: state IDLE, ss_o=1, tip_o=0, load_o=0, receive_data_o=0, overrun_o=0, abort_o=0, bit_cnt_o=0, pend=0, internal counters 0.

## Timing
- All outputs are registered; inputs are sampled at the PCLK rising edge.
- Start, with send_data_i high at edge N while in IDLE and en=1:
  - From edge N: load_o=1 for one cycle, tip_o=1.
  - At edge N+SS_SETUP: ss_o=0.
- Request pending at HOLD exit: IDLE is occupied for exactly one cycle before load_o.
- Final smp sampled at edge M:
  - From edge M: receive_data_o=1 for one cycle and ss_o=1.
  - At edge M+SS_HOLD: IDLE is re-entered.
- Abort: en sampled low at edge K gives ss_o=1 and abort_o=1 from edge K.
- Minimum back-to-back gap between final smp and the next load_o: SS_HOLD+1 cycles.

## Test plan
- Single transfer:
  - Stimulus: DATA_WIDTH=8, en=1, send_data_i pulse, then 8 smp strobes spaced 4 cycles apart.
  - Response: load_o one cycle; ss_o low 2 cycles later; receive_data_o on 8th smp; bit_cnt_o=8; ss_o high; IDLE after 2 cycles.
- Queued request:
  - Stimulus: second send_data_i during XFER.
  - Response: pend=1; second load_o exactly SS_HOLD+1 cycles after the first receive_data_o; no overrun_o.
- Overrun:
  - Stimulus: third send_data_i while pend=1.
  - Response: overrun_o one cycle; exactly two transfers complete.
- Abort:
  - Stimulus: spe_i dropped after 3 smp.
  - Response: abort_o the next edge, ss_o=1, bit_cnt_o=0, no receive_data_o.
  - Repeat with spi_mode_i=01 and spiswai_i=1: same response.
- Disabled request:
  - Stimulus: send_data_i with mstr_i=0, then mstr_i=1 five cycles later.
  - Response: no load_o while disabled; load_o on the cycle after enable.
- Reset mid-XFER:
  - Stimulus: PRESET_n low after 5 smp.
  - Response: all outputs return to reset values asynchronously; the next transfer counts from 0.
